argo_chan_fifo: RTL

ARGO_CHAN_FIFO -- requirements
Module: argo_chan_fifo

---
 rtl/argo_pkg.sv | 31 +++
 rtl/argo_dp_ram.sv | 50 +++++
 rtl/argo_chan_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/argo_pkg.sv
// argo_pkg
// Shared constants and helpers for the argo channel blocks.
//   ARGO_DATA_WIDTH / ARGO_ADDR_WIDTH : default payload and RAM address widths
//   argo_op_e                          : per-cycle handshake combination
//   argo_clog2()                       : ceil(log2(value)), used to size counters
package argo_pkg;

  localparam int ARGO_DATA_WIDTH = 32;
  localparam int ARGO_ADDR_WIDTH = 3;

  // Encoded as {write_fire, read_fire} so it can be built by a direct cast.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } argo_op_e;

  function automatic int argo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/argo_dp_ram.sv
// argo_dp_ram
// Simple dual-port storage: one write port, one synchronous read port.
//   clk        : clock
//   i_rst      : synchronous active-high reset, clears only the read register
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write payload
//   i_rd_en    : read strobe, loads o_rd_data on the next edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, holds while i_rd_en is low
module argo_dp_ram
  import argo_pkg::*;
#(
  parameter int DATA_WIDTH = ARGO_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARGO_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // The array is deliberately left without reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The read register doubles as the FIFO output stage, so it gets a reset
  // to keep the head payload at zero out of reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/argo_chan_fifo.sv
// argo_chan_fifo
// First-word-fall-through channel FIFO built on argo_dp_ram. The RAM read
// register is the output stage, so rd_data/rd_valid come straight from flops.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous discard of all contents
//   wr_valid/ready    : producer handshake, wr_data payload
//   rd_valid/ready    : consumer handshake, rd_data head payload
//   count             : entries held, including the one in the output stage
//   almost_full/empty : registered threshold flags derived from count
module argo_chan_fifo
  import argo_pkg::*;
#(
  parameter int DATA_WIDTH = ARGO_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARGO_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CNT_W = argo_clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      ONE_CNT   = CNT_W'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_valid;
  logic                  r_wr_ready;
  logic                  r_afull;
  logic                  r_aempty;

  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_mem_avail;
  logic                  w_fetch;
  logic                  w_ram_wr_en;
  logic                  w_ram_rd_en;
  argo_op_e              w_op;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
  logic                  w_clear;

  always_comb begin
    w_clear   = rst || flush;
    w_wr_fire = wr_valid && r_wr_ready;
    w_rd_fire = r_rd_valid && rd_ready;

    // Words still sitting in the RAM (not yet in the output stage). Only
    // words written on earlier edges count, which avoids reading an address
    // in the same cycle it is being written.
    w_mem_avail = r_rd_valid ? (r_count > ONE_CNT) : (r_count != '0);

    // Load the output stage when it is empty or being drained this cycle.
    w_fetch = w_mem_avail && (!r_rd_valid || rd_ready);

    w_op = argo_op_e'({w_wr_fire, w_rd_fire});
    w_count_nxt = r_count;
    case (w_op)
      OP_WR:   w_count_nxt = r_count + ONE_CNT;
      OP_RD:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase

    // Explicit wrap keeps the pointers correct for non-power-of-two DEPTH.
    w_wr_ptr_nxt = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
    w_rd_ptr_nxt = (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);

    w_ram_wr_en = w_wr_fire && !w_clear;
    w_ram_rd_en = w_fetch && !w_clear;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b1;
      r_afull    <= (0 >= AFULL_LVL);
      r_aempty   <= (0 <= AEMPTY_LVL);
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_fetch) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_rd_valid <= w_fetch || (r_rd_valid && !rd_ready);
      r_count    <= w_count_nxt;
      // Ready is computed from the next count so it is a pure flop output;
      // a read completing while full frees space only for the following cycle.
      r_wr_ready <= (w_count_nxt != FULL_CNT);
      r_afull    <= (int'(w_count_nxt) >= AFULL_LVL);
      r_aempty   <= (int'(w_count_nxt) <= AEMPTY_LVL);
    end
  end

  argo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk        (clk),
    .i_rst      (rst),
    .i_wr_en    (w_ram_wr_en),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_ram_rd_en),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (rd_data)
  );

  assign wr_ready     = r_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign count        = (ADDR_WIDTH + 1)'(r_count);
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule
